fetch_decode_buffer: RTL and testbench

- Two-entry first-word-fall-through queue between instruction fetch and decode.
- Captures {PC, instruction} pairs from fetch under a valid/ready handshake and presents the oldest pair to decode.
- Predecodes the standard RV64I fields and flags misaligned PCs.
- Supports a pipeline flush on branch redirect, which discards wrong-path instructions.

---
 rtl/fetch_decode_buffer.sv | 177 +++++++++++++++++
 tb/tb_fetch_decode_buffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_buffer.sv
// ============================================================================
// fetch_decode_buffer
//
// Small first-word-fall-through queue sitting between instruction fetch and
// decode. Fetch hands over {pc, instruction} pairs with a valid/ready
// handshake. Decode always sees the oldest pair on the out_* side, already
// split into the standard RV64I fields. A flush (branch redirect) throws away
// every buffered wrong-path instruction in one cycle.
//
// Parameters
//   XLEN      - width of the program counter
//   ILEN      - width of an instruction word (field split assumes 32 bits)
//   DEPTH     - number of entries; power of two, at least 2
//   NOP_INSTR - word shown on out_instr while the buffer is empty
//
// Ports
//   clk            - system clock, all state changes on the rising edge
//   reset          - asynchronous active-high reset, empties the buffer
//   flush          - synchronous kill of every buffered entry
//   in_valid       - fetch offers a pair this cycle
//   in_ready       - buffer has room (depends on registered occupancy only)
//   in_pc          - PC of the offered instruction
//   in_instr       - offered instruction word
//   out_valid      - head entry holds a real instruction
//   out_ready      - decode takes the head entry this cycle
//   out_pc         - PC of the head entry (0 when empty)
//   out_instr      - head instruction (NOP_INSTR when empty)
//   out_misaligned - head PC has a nonzero low two bits
//   out_opcode     - head instruction [6:0]
//   out_rd         - head instruction [11:7]
//   out_funct3     - head instruction [14:12]
//   out_rs1        - head instruction [19:15]
//   out_rs2        - head instruction [24:20]
//   out_funct7     - head instruction [31:25]
//   out_is_branch  - head is valid and is a conditional branch
//   count          - current number of buffered entries
// ============================================================================
module fetch_decode_buffer #(
    parameter int unsigned     XLEN      = 64,
    parameter int unsigned     ILEN      = 32,
    parameter int unsigned     DEPTH     = 2,
    parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [ILEN-1:0]          in_instr,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [ILEN-1:0]          out_instr,
    output logic                     out_misaligned,
    output logic [6:0]               out_opcode,
    output logic [4:0]               out_rd,
    output logic [2:0]               out_funct3,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [6:0]               out_funct7,
    output logic                     out_is_branch,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned     PTR_W      = $clog2(DEPTH);
    localparam int unsigned     CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [6:0]      OPC_BRANCH = 7'b1100011;

    // Entry storage. Data arrays carry no reset; the valid bits and the
    // occupancy counter decide whether anything in them is meaningful.
    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [ILEN-1:0]  instr_mem [DEPTH];
    logic             mis_mem   [DEPTH];
    logic [DEPTH-1:0] entry_valid;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;

    logic             push;
    logic             pop;
    logic             head_live;

    // Handshake qualification. A push needs room and a pop needs an entry;
    // both are ignored on a flush cycle further down, where flush wins.
    always_comb begin
        in_ready  = (count_q != FULL_COUNT);
        out_valid = (count_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Occupancy update. A simultaneous push and pop leaves the count alone,
    // which is what keeps a steady one-in/one-out stream at one entry.
    always_comb begin
        count_next = count_q;
        unique case ({push, pop})
            2'b10:   count_next = count_q + CNT_W'(1);
            2'b01:   count_next = count_q - CNT_W'(1);
            default: count_next = count_q;
        endcase
    end

    // Control state: pointers, occupancy and per-entry valid bits. Reset
    // and flush both collapse the queue back to its empty starting point.
    // Pointer increments wrap naturally because DEPTH is a power of two.
    // Push and pop never address the same slot in one cycle: the pointers
    // only meet when the buffer is empty (no pop) or full (no push).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            entry_valid <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            entry_valid <= '0;
        end else begin
            count_q <= count_next;
            if (pop) begin
                rd_ptr              <= rd_ptr + PTR_W'(1);
                entry_valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr              <= wr_ptr + PTR_W'(1);
                entry_valid[wr_ptr] <= 1'b1;
            end
        end
    end

    // Data capture. The misaligned flag is computed once on the way in so
    // the head mux only has to select it. The PC is kept bit-for-bit.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
            mis_mem[wr_ptr]   <= |in_pc[1:0];
        end
    end

    // Head presentation. There is no bypass from the input side, so a push
    // into an empty buffer becomes visible one cycle later. An empty buffer
    // shows a canonical NOP at PC 0 so decode never sees stale data.
    always_comb begin
        head_live      = out_valid && entry_valid[rd_ptr];
        out_pc         = '0;
        out_instr      = NOP_INSTR;
        out_misaligned = 1'b0;
        if (head_live) begin
            out_pc         = pc_mem[rd_ptr];
            out_instr      = instr_mem[rd_ptr];
            out_misaligned = mis_mem[rd_ptr];
        end
    end

    // Predecode of the fixed RV64I field positions, taken straight from the
    // head word so the empty case naturally decodes as the NOP.
    always_comb begin
        out_opcode    = out_instr[6:0];
        out_rd        = out_instr[11:7];
        out_funct3    = out_instr[14:12];
        out_rs1       = out_instr[19:15];
        out_rs2       = out_instr[24:20];
        out_funct7    = out_instr[31:25];
        out_is_branch = out_valid && (out_instr[6:0] == OPC_BRANCH);
    end

    assign count = count_q;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// ============================================================================
// tb_fetch_decode_buffer
//
// Directed and randomized stimulus for fetch_decode_buffer. A queue of
// {pc, instr} pairs models the buffer contents; expected outputs are derived
// from that queue each cycle. Inputs change and outputs are sampled at the
// falling edge; the DUT updates on the rising edge.
// ============================================================================
module tb_fetch_decode_buffer;

    localparam int          XLEN  = 64;
    localparam int          ILEN  = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [XLEN-1:0]        in_pc;
    logic [ILEN-1:0]        in_instr;
    logic                   out_valid;
    logic                   out_ready;
    logic [XLEN-1:0]        out_pc;
    logic [ILEN-1:0]        out_instr;
    logic                   out_misaligned;
    logic [6:0]             out_opcode;
    logic [4:0]             out_rd;
    logic [2:0]             out_funct3;
    logic [4:0]             out_rs1;
    logic [4:0]             out_rs2;
    logic [6:0]             out_funct7;
    logic                   out_is_branch;
    logic [$clog2(DEPTH):0] count;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t model_q[$];
    int     errors = 0;
    int     checks = 0;

    fetch_decode_buffer #(
        .XLEN      (XLEN),
        .ILEN      (ILEN),
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_instr       (in_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_misaligned (out_misaligned),
        .out_opcode     (out_opcode),
        .out_rd         (out_rd),
        .out_funct3     (out_funct3),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .out_funct7     (out_funct7),
        .out_is_branch  (out_is_branch),
        .count          (count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports any mismatch.
    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Compare every output against what the queue model says the head and
    // occupancy should be right now.
    task automatic checkOutput();
        logic        e_valid;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        e_valid = (model_q.size() != 0);
        e_pc    = e_valid ? model_q[0].pc    : 64'd0;
        e_instr = e_valid ? model_q[0].instr : NOP;
        check("out_valid",      64'(out_valid),      64'(e_valid));
        check("in_ready",       64'(in_ready),       64'(model_q.size() < DEPTH));
        check("count",          64'(count),          64'(model_q.size()));
        check("out_pc",         out_pc,              e_pc);
        check("out_instr",      64'(out_instr),      64'(e_instr));
        check("out_misaligned", 64'(out_misaligned), 64'(e_valid && (e_pc % 4 != 0)));
        check("out_opcode",     64'(out_opcode),     64'(e_instr % 128));
        check("out_rd",         64'(out_rd),         64'((e_instr >> 7) % 32));
        check("out_funct3",     64'(out_funct3),     64'((e_instr >> 12) % 8));
        check("out_rs1",        64'(out_rs1),        64'((e_instr >> 15) % 32));
        check("out_rs2",        64'(out_rs2),        64'((e_instr >> 20) % 32));
        check("out_funct7",     64'(out_funct7),     64'(e_instr >> 25));
        check("out_is_branch",  64'(out_is_branch),  64'(e_valid && (e_instr % 128 == 99)));
    endtask

    // One clock cycle: check the current state, drive the new inputs, then
    // advance the model by the handshake rules and let the rising edge pass.
    task automatic applyStimulus(input logic v, input logic [63:0] pc,
                                 input logic [31:0] ins, input logic rdy,
                                 input logic fl);
        int     sz;
        entry_t e;
        @(negedge clk);
        checkOutput();
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = rdy;
        flush     = fl;
        sz        = model_q.size();
        if (fl) begin
            model_q.delete();
        end else begin
            if (rdy && sz != 0) void'(model_q.pop_front());
            if (v && sz != DEPTH) begin
                e.pc    = pc;
                e.instr = ins;
                model_q.push_back(e);
            end
        end
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] rnd;
        logic [63:0] rpc;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput();
        reset = 1'b0;

        // Single push with decode stalled, visible one cycle later
        applyStimulus(1'b1, 64'h0, 32'h00500093, 1'b0, 1'b0);
        #1;
        check("t1_valid",  64'(out_valid),  64'd1);
        check("t1_opcode", 64'(out_opcode), 64'h13);
        check("t1_rd",     64'(out_rd),     64'd1);
        check("t1_count",  64'(count),      64'd1);
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

        // Fill to full, rejected third push, then drain in order
        applyStimulus(1'b1, 64'h0, 32'h00100113, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h4, 32'h00200193, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h8, 32'h00300213, 1'b0, 1'b0);
        #1;
        check("t2_count",    64'(count),    64'd2);
        check("t2_in_ready", 64'(in_ready), 64'd0);
        check("t2_head",     out_pc,        64'h0);
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        #1;
        check("t2_pop1_pc", out_pc, 64'h4);
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        #1;
        check("t2_empty_valid", 64'(out_valid), 64'd0);
        check("t2_empty_instr", 64'(out_instr), 64'h13);

        // Steady stream: one in, one out, occupancy pinned at 1
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 64'(i * 4), 32'h00000033 | 32'(i << 7), 1'b1, 1'b0);
            #1;
            check("t3_count",  64'(count), 64'd1);
            check("t3_out_pc", out_pc,     64'(i * 4));
        end
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

        // Flush with a simultaneous push and pop; both are discarded
        applyStimulus(1'b1, 64'h10, 32'h00a00513, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h14, 32'h00b00593, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'h18, 32'h00c00613, 1'b1, 1'b1);
        #1;
        check("t4_count",    64'(count),     64'd0);
        check("t4_valid",    64'(out_valid), 64'd0);
        check("t4_in_ready", 64'(in_ready),  64'd1);
        applyStimulus(1'b1, 64'h100, 32'h00d00693, 1'b0, 1'b0);
        #1;
        check("t4_redirect_pc", out_pc,     64'h100);
        check("t4_count1",      64'(count), 64'd1);
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

        // Misaligned branch predecode
        applyStimulus(1'b1, 64'h6, 32'h00c58463, 1'b0, 1'b0);
        #1;
        check("t5_misaligned", 64'(out_misaligned), 64'd1);
        check("t5_is_branch",  64'(out_is_branch),  64'd1);
        check("t5_rs1",        64'(out_rs1),        64'd11);
        check("t5_rs2",        64'(out_rs2),        64'd12);
        check("t5_funct3",     64'(out_funct3),     64'd0);
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between clock edges
        applyStimulus(1'b1, 64'h20, 32'h00e00713, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        model_q.delete();
        #1;
        check("t6_valid",    64'(out_valid), 64'd0);
        check("t6_in_ready", 64'(in_ready),  64'd1);
        check("t6_count",    64'(count),     64'd0);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom();
            if ($urandom_range(0, 3) == 0) rnd = {rnd[31:7], 7'h63};
            rpc = {$urandom(), $urandom()};
            if ($urandom_range(0, 1) == 0) rpc[1:0] = 2'b00;
            applyStimulus($urandom_range(0, 3) != 0, rpc, rnd,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
        end

        // Drain and final state
        repeat (3) applyStimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
